// File: rtl/pipe_pkg.sv
// Shared constants for the ID->EXE issue stage: operand forward selects,
// ALU control width and the jal link register number.
package pipe_pkg;

  localparam int ALUC_W = 4;
  localparam int JAL_RN = 31;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF      = 2'd0;
  localparam fwd_sel_t FWD_EXE     = 2'd1;
  localparam fwd_sel_t FWD_MEM_ALU = 2'd2;
  localparam fwd_sel_t FWD_MEM_MEM = 2'd3;

endpackage

// File: rtl/pipe_id_issue_if.sv
// ID/EXE register bundle handed from the issue stage (master) to the
// EXE stage (slave).
interface pipe_id_issue_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  import pipe_pkg::*;

  logic [DW-1:0]     ea;
  logic [DW-1:0]     eb;
  logic [DW-1:0]     eimm;
  logic [DW-1:0]     epc4;
  logic [RW-1:0]     ern0;
  logic [ALUC_W-1:0] ealuc;
  logic              ealuimm;
  logic              eshift;
  logic              ejal;
  logic              ewreg;
  logic              em2reg;
  logic              ewmem;

  modport master (
    output ea, eb, eimm, epc4, ern0, ealuc,
    output ealuimm, eshift, ejal, ewreg, em2reg, ewmem
  );

  modport slave (
    input ea, eb, eimm, epc4, ern0, ealuc,
    input ealuimm, eshift, ejal, ewreg, em2reg, ewmem
  );

endinterface

// File: rtl/pipe_fwd_sel.sv
// One operand's forwarding decision: EXE result beats MEM result beats the
// register file, and r0 always reads the register file.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] rn,
  input  logic [DW-1:0] rf_q,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic [RW-1:0] ern,
  input  logic [DW-1:0] ealu,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic [RW-1:0] mrn,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  output logic [DW-1:0] q
);

  fwd_sel_t sel;

  // A load in EXE has no data yet; that case is covered by the stall instead.
  always_comb begin
    sel = FWD_RF;
    if ((rn != '0) && ewreg && !em2reg && (ern == rn))
      sel = FWD_EXE;
    else if ((rn != '0) && mwreg && (mrn == rn))
      sel = mm2reg ? FWD_MEM_MEM : FWD_MEM_ALU;
  end

  always_comb begin
    unique case (sel)
      FWD_EXE:     q = ealu;
      FWD_MEM_ALU: q = malu;
      FWD_MEM_MEM: q = mmo;
      default:     q = rf_q;
    endcase
  end

endmodule

// File: rtl/pipe_id_issue.sv
// ID->EXE issue stage: operand forwarding, load-use stall/bubble, the
// ID/EXE register and a saturating stall-cycle counter.
module pipe_id_issue
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW-1:0]     drs,
  input  logic [RW-1:0]     drt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [DW-1:0]     qa,
  input  logic [DW-1:0]     qb,
  input  logic [DW-1:0]     dimm,
  input  logic [DW-1:0]     dpc4,
  input  logic [RW-1:0]     drn0,
  input  logic [ALUC_W-1:0] daluc,
  input  logic              daluimm,
  input  logic              dshift,
  input  logic              djal,
  input  logic              dwreg,
  input  logic              dm2reg,
  input  logic              dwmem,
  input  logic [RW-1:0]     ern,
  input  logic              ewreg_fb,
  input  logic              em2reg_fb,
  input  logic [DW-1:0]     ealu,
  input  logic [RW-1:0]     mrn,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [DW-1:0]     malu,
  input  logic [DW-1:0]     mmo,
  input  logic              flush,
  output logic              stall,
  pipe_id_issue_if.master   ex,
  output logic [CW-1:0]     stall_cnt
);

  logic [DW-1:0] fwd_a, fwd_b;
  logic          bubble;

  pipe_fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
    .rn(drs), .rf_q(qa), .ewreg(ewreg_fb), .em2reg(em2reg_fb), .ern(ern),
    .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu),
    .mmo(mmo), .q(fwd_a)
  );

  pipe_fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
    .rn(drt), .rf_q(qb), .ewreg(ewreg_fb), .em2reg(em2reg_fb), .ern(ern),
    .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu),
    .mmo(mmo), .q(fwd_b)
  );

  // Load in EXE whose result a live source operand needs: hold ID one cycle.
  assign stall  = ewreg_fb & em2reg_fb & (ern != '0) &
                  ((use_rs & (ern == drs)) | (use_rt & (ern == drt)));
  assign bubble = stall | flush;

  logic [DW-1:0]     ea_d, eb_d, eimm_d, epc4_d;
  logic [DW-1:0]     ea_q, eb_q, eimm_q, epc4_q;
  logic [RW-1:0]     ern0_d, ern0_q;
  logic [ALUC_W-1:0] ealuc_d, ealuc_q;
  logic              ealuimm_d, eshift_d, ejal_d, ewreg_d, em2reg_d, ewmem_d;
  logic              ealuimm_q, eshift_q, ejal_q, ewreg_q, em2reg_q, ewmem_q;
  logic [CW-1:0]     cnt_d, cnt_q;

  always_comb begin
    ea_d      = fwd_a;
    eb_d      = fwd_b;
    eimm_d    = dimm;
    epc4_d    = dpc4;
    ern0_d    = drn0;
    ealuc_d   = daluc;
    ealuimm_d = daluimm;
    eshift_d  = dshift;
    ejal_d    = djal;
    ewreg_d   = dwreg;
    em2reg_d  = dm2reg;
    ewmem_d   = dwmem;
    if (bubble) begin
      ea_d      = '0;
      eb_d      = '0;
      eimm_d    = '0;
      epc4_d    = '0;
      ern0_d    = '0;
      ealuc_d   = '0;
      ealuimm_d = 1'b0;
      eshift_d  = 1'b0;
      ejal_d    = 1'b0;
      ewreg_d   = 1'b0;
      em2reg_d  = 1'b0;
      ewmem_d   = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CW{1'b1}}))
      cnt_d = cnt_q + CW'(1);
  end

  // ---- ID/EXE register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q      <= '0;
      eb_q      <= '0;
      eimm_q    <= '0;
      epc4_q    <= '0;
      ern0_q    <= '0;
      ealuc_q   <= '0;
      ealuimm_q <= 1'b0;
      eshift_q  <= 1'b0;
      ejal_q    <= 1'b0;
      ewreg_q   <= 1'b0;
      em2reg_q  <= 1'b0;
      ewmem_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      eimm_q    <= eimm_d;
      epc4_q    <= epc4_d;
      ern0_q    <= ern0_d;
      ealuc_q   <= ealuc_d;
      ealuimm_q <= ealuimm_d;
      eshift_q  <= eshift_d;
      ejal_q    <= ejal_d;
      ewreg_q   <= ewreg_d;
      em2reg_q  <= em2reg_d;
      ewmem_q   <= ewmem_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex.ea      = ea_q;
  assign ex.eb      = eb_q;
  assign ex.eimm    = eimm_q;
  assign ex.epc4    = epc4_q;
  assign ex.ern0    = ern0_q;
  assign ex.ealuc   = ealuc_q;
  assign ex.ealuimm = ealuimm_q;
  assign ex.eshift  = eshift_q;
  assign ex.ejal    = ejal_q;
  assign ex.ewreg   = ewreg_q;
  assign ex.em2reg  = em2reg_q;
  assign ex.ewmem   = ewmem_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_id_issue.sv
// Bench for pipe_id_issue: directed cases with literal expectations plus a
// randomized run compared every cycle against a rule-level model.
module tb_pipe_id_issue;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] drs, drt, drn0, ern, mrn;
  logic          use_rs, use_rt;
  logic [DW-1:0] qa, qb, dimm, dpc4, ealu, malu, mmo;
  logic [3:0]    daluc;
  logic          daluimm, dshift, djal, dwreg, dm2reg, dwmem;
  logic          ewreg_fb, em2reg_fb, mwreg, mm2reg, flush;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  pipe_id_issue_if #(.DW(DW), .RW(RW)) ex_if ();

  pipe_id_issue #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .drs(drs), .drt(drt), .use_rs(use_rs), .use_rt(use_rt),
    .qa(qa), .qb(qb), .dimm(dimm), .dpc4(dpc4), .drn0(drn0), .daluc(daluc),
    .daluimm(daluimm), .dshift(dshift), .djal(djal), .dwreg(dwreg),
    .dm2reg(dm2reg), .dwmem(dwmem), .ern(ern), .ewreg_fb(ewreg_fb),
    .em2reg_fb(em2reg_fb), .ealu(ealu), .mrn(mrn), .mwreg(mwreg),
    .mm2reg(mm2reg), .malu(malu), .mmo(mmo), .flush(flush), .stall(stall),
    .ex(ex_if), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern0;
    logic [3:0]  aluc;
    logic        aluimm, shift, jal, wreg, m2reg, wmem;
  } exo_t;

  exo_t m;
  int   m_cnt;

  function automatic logic [31:0] m_operand(logic [4:0] rn, logic [31:0] rf);
    if (rn == 0) return rf;
    if (ewreg_fb && !em2reg_fb && ern == rn) return ealu;
    if (mwreg && mrn == rn) return mm2reg ? mmo : malu;
    return rf;
  endfunction

  function automatic logic m_stall();
    if (!(ewreg_fb && em2reg_fb) || ern == 0) return 1'b0;
    return (use_rs && ern == drs) || (use_rt && ern == drt);
  endfunction

  function automatic exo_t zero_exo();
    exo_t z;
    z.ea = 0; z.eb = 0; z.eimm = 0; z.epc4 = 0; z.ern0 = 0; z.aluc = 0;
    z.aluimm = 0; z.shift = 0; z.jal = 0; z.wreg = 0; z.m2reg = 0; z.wmem = 0;
    return z;
  endfunction

  initial begin
    m = zero_exo();
    m_cnt = 0;
  end

  // Model steps on every edge; DUT compared each cycle once enabled.
  initial begin
    exo_t nx;
    logic s;
    forever begin
      @(negedge clk);
      if (chk_en) chk("stall", {31'b0, stall}, {31'b0, m_stall()});
      @(posedge clk);
      s = m_stall();
      if (rst) begin
        m = zero_exo();
        m_cnt = 0;
      end else begin
        if (s || flush) nx = zero_exo();
        else begin
          nx.ea = m_operand(drs, qa);   nx.eb = m_operand(drt, qb);
          nx.eimm = dimm;  nx.epc4 = dpc4;  nx.ern0 = drn0;  nx.aluc = daluc;
          nx.aluimm = daluimm; nx.shift = dshift; nx.jal = djal;
          nx.wreg = dwreg; nx.m2reg = dm2reg; nx.wmem = dwmem;
        end
        m = nx;
        if (s && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      #1;
      if (chk_en) begin
        chk("ea", ex_if.ea, m.ea);
        chk("eb", ex_if.eb, m.eb);
        chk("eimm", ex_if.eimm, m.eimm);
        chk("epc4", ex_if.epc4, m.epc4);
        chk("ern0", {27'b0, ex_if.ern0}, {27'b0, m.ern0});
        chk("ealuc", {28'b0, ex_if.ealuc}, {28'b0, m.aluc});
        chk("ctl", {26'b0, ex_if.ealuimm, ex_if.eshift, ex_if.ejal, ex_if.ewreg, ex_if.em2reg, ex_if.ewmem},
                   {26'b0, m.aluimm, m.shift, m.jal, m.wreg, m.m2reg, m.wmem});
        chk("stall_cnt", {28'b0, stall_cnt}, m_cnt[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 0; drs = 0; drt = 0; drn0 = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0; qa = 0; qb = 0; dimm = 0; dpc4 = 0;
    ealu = 0; malu = 0; mmo = 0; daluc = 0; daluimm = 0; dshift = 0;
    djal = 0; dwreg = 0; dm2reg = 0; dwmem = 0; ewreg_fb = 0;
    em2reg_fb = 0; mwreg = 0; mm2reg = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    drs = 5'($urandom_range(0, 7)); drt = 5'($urandom_range(0, 7));
    drn0 = 5'($urandom_range(0, 31)); ern = 5'($urandom_range(0, 7));
    mrn = 5'($urandom_range(0, 7));
    use_rs = 1'($urandom); use_rt = 1'($urandom);
    qa = $urandom; qb = $urandom; dimm = $urandom; dpc4 = $urandom;
    ealu = $urandom; malu = $urandom; mmo = $urandom;
    daluc = 4'($urandom); daluimm = 1'($urandom); dshift = 1'($urandom);
    djal = 1'($urandom); dwreg = 1'($urandom); dm2reg = 1'($urandom);
    dwmem = 1'($urandom); ewreg_fb = 1'($urandom); em2reg_fb = 1'($urandom);
    mwreg = 1'($urandom); mm2reg = 1'($urandom);
    flush = ($urandom_range(0, 7) == 0);
    rst = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    idle();
    // Reset with busy ID inputs
    rst = 1; dwreg = 1; drn0 = 5'd9; qa = 32'hAA; qb = 32'hBB; drs = 1; drt = 2;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ewreg", {31'b0, ex_if.ewreg}, 32'd0);
    chk("rst_ea", ex_if.ea, 32'd0);
    chk("rst_cnt", {28'b0, stall_cnt}, 32'd0);

    // add $3,$1,$2
    idle(); drs = 1; drt = 2; use_rs = 1; use_rt = 1; qa = 5; qb = 7;
    drn0 = 3; dwreg = 1;
    tick();
    chk("add_ea", ex_if.ea, 32'd5);
    chk("add_eb", ex_if.eb, 32'd7);
    chk("add_ewreg", {31'b0, ex_if.ewreg}, 32'd1);
    chk("add_ern0", {27'b0, ex_if.ern0}, 32'd3);

    // EXE forward and r0 exclusion
    idle(); ewreg_fb = 1; ern = 4; ealu = 32'h10; drs = 4; use_rs = 1; qa = 0;
    tick();
    chk("fwd_exe", ex_if.ea, 32'h10);
    ern = 0; drs = 0; qa = 32'h77;
    tick();
    chk("fwd_r0", ex_if.ea, 32'h77);

    // EXE beats MEM; MEM load data
    idle(); drs = 5; use_rs = 1; ewreg_fb = 1; ern = 5; ealu = 1;
    mwreg = 1; mrn = 5; malu = 2;
    tick();
    chk("prio_exe", ex_if.ea, 32'd1);
    ewreg_fb = 0; mm2reg = 1; mmo = 9;
    tick();
    chk("fwd_mem_mo", ex_if.ea, 32'd9);

    // Load-use on rt
    idle(); ewreg_fb = 1; em2reg_fb = 1; ern = 6; drt = 6; use_rt = 1;
    dwreg = 1; dwmem = 1; qb = 32'h3;
    #1 chk("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {30'b0, ex_if.ewreg, ex_if.ewmem}, 32'd0);
    chk("lu_cnt", {28'b0, stall_cnt}, 32'd1);
    ewreg_fb = 0; em2reg_fb = 0; mwreg = 1; mm2reg = 1; mrn = 6; mmo = 32'h55;
    #1 chk("lu_release", {31'b0, stall}, 32'd0);
    tick();
    chk("lu_eb_mmo", ex_if.eb, 32'h55);
    idle(); ewreg_fb = 1; em2reg_fb = 1; ern = 6; drt = 6; use_rt = 0;
    #1 chk("lu_unused", {31'b0, stall}, 32'd0);
    tick();

    // Flush bubble, then reset mid-stall
    idle(); dwreg = 1; drn0 = 7; flush = 1;
    tick();
    chk("flush_bubble", {31'b0, ex_if.ewreg}, 32'd0);
    idle(); ewreg_fb = 1; em2reg_fb = 1; ern = 2; drs = 2; use_rs = 1; flush = 1;
    tick();
    chk("flush_stall_cnt", {28'b0, stall_cnt}, 32'd2);
    rst = 1;
    tick();
    chk("rst_mid_stall", {28'b0, stall_cnt}, 32'd0);

    // Saturation
    rst = 0; flush = 0;
    repeat (20) tick();
    chk("cnt_sat", {28'b0, stall_cnt}, 32'd15);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick();
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_id_issue.md
Name: pipe_id_issue

Overview:
- Issue stage at the ID→EXE boundary of the 5-stage pipelined CPU. It feeds the EXE stage the operands and control it consumes: ealuc, ealuimm, ea, eb, eimm, eshift, ern0, epc4, ejal.
- Resolves operand forwarding from the EXE and MEM stages and detects load-use hazards, stalling IF/ID and inserting a bubble when needed.
- Owns the ID/EXE pipeline register and a stall-cycle performance counter.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-number width.
- CW, 32, stall counter width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- drs, drt  in  RW each  source register numbers of the instruction in ID.
- use_rs, use_rt  in  1 each  the instruction reads rs / rt.
- qa, qb  in  DW each  register-file read data.
- dimm, dpc4  in  DW each  extended immediate; PC+4 of the ID instruction.
- drn0  in  RW  temporary destination register number.
- daluc  in  4  ALU control.
- daluimm, dshift, djal, dwreg, dm2reg, dwmem  in  1 each  decoded control bits.
- ern  in  RW  final destination register number of the instruction in EXE (already forced to 31 on jal).
- ewreg_fb, em2reg_fb  in  1 each  write-enable and load flag of the instruction in EXE (equal to this block's own ewreg / em2reg).
- ealu  in  DW  EXE-stage result.
- mrn  in  RW  destination register number in MEM.
- mwreg, mm2reg  in  1 each  write-enable and load flag in MEM.
- malu, mmo  in  DW each  MEM-stage ALU result; memory read data.
- flush  in  1  squash the ID instruction (control redirect).
- stall  out  1  combinational; holds PC and the IF/ID register.
- ea, eb, eimm, epc4  out  DW each  registered EXE operands.
- ern0  out  RW  registered temporary destination register number.
- ealuc  out  4  registered ALU control.
- ealuimm, eshift, ejal, ewreg, em2reg, ewmem  out  1 each  registered control bits.
- stall_cnt  out  CW  count of load-use stall cycles.

Behaviour:
- Reset (rst=1 at a clock edge): every registered output = 0, stall_cnt = 0. Reset takes priority over stall and flush, including mid-stall. stall is combinational and follows its equation.
- Forwarding, computed per operand in ID, combinational:
  - r0 is never forwarded.
  - For rs: if ewreg_fb & !em2reg_fb & ern==drs & drs!=0, select ealu.
  - Else if mwreg & mrn==drs & drs!=0, select mmo when mm2reg, otherwise malu.
  - Else select qa.
  - rt uses the same rule with drt and qb.
- Load-use hazard:
  - stall = ewreg_fb & em2reg_fb & ern!=0 & ((use_rs & ern==drs) | (use_rt & ern==drt)).
  - A hazard on an unused operand does not stall.
- Bubble: on a clock edge with stall | flush, load ewreg = em2reg = ewmem = ejal = 0 and all other outputs = 0.
  - On stall, the ID instruction stays in place and re-issues next cycle, when the load is in MEM and mmo is forwarded. Latency is exactly 1 stall cycle per load-use.
  - flush and stall together: bubble, and stall still asserts. The upstream redirect handles PC priority.
- Normal edge: all e* outputs take the d* / forwarded values. Latency is 1 cycle from ID to the EXE outputs.
- stall_cnt:
  - Increments by 1 on each edge where stall=1 and rst=0.
  - Saturates at all-ones, with no wrap.
- No internal FSM beyond the register bundle and counter. Back-to-back loads with dependents produce one bubble each.

Decomposition:
- Shared package pipe_pkg holds:
  - forward-select constants FWD_RF=0, FWD_EXE=1, FWD_MEM_ALU=2, FWD_MEM_MEM=3;
  - the ALUC width of 4;
  - the jal link register number 31.
- One natural sub-module, pipe_fwd_sel: per-operand select logic plus a 4:1 mux, instantiated twice (rs, rt).

Test Plan:
- Reset: hold rst for 2 cycles with nonzero d* inputs → all outputs 0, stall_cnt=0. Then release and issue add $3,$1,$2 with qa=5, qb=7 → next cycle ea=5, eb=7, ewreg=1, ern0=3.
- EXE forward: EXE holds ALU op to $4 (ealu=0x10) while ID uses rs=$4, qa=0 → ea=0x10. Same case with the destination being $0 and ealu=0x10 → ea=qa.
- Priority: EXE and MEM both write $5 (ealu=1, malu=2) → ea=1. With only MEM writing $5 and mm2reg=1, mmo=9 → ea=9.
- Load-use: lw $6 in EXE, ID uses rt=$6 with use_rt=1 → stall=1 for exactly 1 cycle and bubble (ewreg=0, ewmem=0); stall_cnt=1. Next cycle eb=mmo. With use_rt=0 → no stall.
- Flush during stall plus reset mid-stall: flush=1 → bubble. rst=1 while stall is active → outputs 0, stall_cnt=0.
- Counter saturation: with CW=4, force 20 stall cycles → stall_cnt=15.
